// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared encodings for the 3x3 window filter.
// Mode and FSM enums, gaussian weight helper, pipeline latency.
package imgproc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_GAUSS = 2'd1,
    MODE_LAPL  = 2'd2,
    MODE_PASS3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int LAT         = 2;
  localparam int GAUSS_SHIFT = 4;

  // 1 2 1 / 2 4 2 / 1 2 1 as a left shift
  function automatic int unsigned gauss_sh(
    input int r,
    input int c
  );
    return ((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0);
  endfunction

endpackage

// File: rtl/imgproc_line_buffer.sv
// imgproc_line_buffer: DEPTH-deep circular delay line.
// Ports: clk, rst, push, wr_data in; rd_data out (value pushed DEPTH pushes ago).
module imgproc_line_buffer
  import imgproc_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  // read-before-write at the same slot gives exactly DEPTH pushes of delay
  assign rd_data = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rgb_window_filter.sv
// rgb_window_filter: streaming 3x3 filter, shared buffers for CHANNELS channels.
// Ports: clk, rst, mode, inputDataValid/inputData -> inputReady;
//  outputDataValid/outputData/frameDone. IMGPROC_BORDER_REPLICATE_EN clamps borders.
module rgb_window_filter
  import imgproc_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         inputDataValid,
  input  logic [CHANNELS*DATA_W-1:0]   inputData,
  output logic                         inputReady,
  output logic                         outputDataValid,
  output logic [CHANNELS*DATA_W-1:0]   outputData,
  output logic                         frameDone
);
  localparam int PW    = CHANNELS * DATA_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H + 2);
  localparam int ACC_W = DATA_W + 4;
  localparam int NS_W  = DATA_W + 3;
  localparam int LAP_W = DATA_W + 5;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [RW-1:0]    pr_q, pr_d, cr_q, cr_d;
  logic [CW-1:0]    pc_q, pc_d, cc_q, cc_d;
  logic [PW-1:0]    win_q [3][3];
  logic [PW-1:0]    win_d [3][3];
  logic [LAT-1:0]   vld_q, vld_d, last_q, last_d;
  logic             s1_top_q, s1_bot_q, s1_lft_q, s1_rgt_q;
  logic             s1_top_d, s1_bot_d, s1_lft_d, s1_rgt_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [PW-1:0]    out_data_q, out_data_d;

  logic             accept, push, emit, last_in, last_out;
  logic [PW-1:0]    push_data, lb0_out, lb1_out, res;
  logic [PW-1:0]    tap_px [3][3];
  logic             row_out, col_out;
  logic [DATA_W-1:0] px, ctr, gres, lres;
  logic [ACC_W-1:0] gsum;
  logic [NS_W-1:0]  nsum;
  logic signed [LAP_W-1:0] lap;
  logic [LAP_W-1:0] mag;

  assign inputReady = (state_q != ST_FLUSH);
  assign accept     = inputDataValid && inputReady;
  assign push       = accept || (state_q == ST_FLUSH);
  assign push_data  = (state_q == ST_FLUSH) ? '0 : inputData;
  // centre lags the newest pushed pixel by one line plus one pixel
  assign emit       = push && ((pr_q >= RW'(2)) ||
                      ((pr_q == RW'(1)) && (pc_q != '0)));
  assign last_in    = (pr_q == RW'(IMG_H - 1)) && (pc_q == CW'(IMG_W - 1));
  assign last_out   = (cr_q == RW'(IMG_H - 1)) && (cc_q == CW'(IMG_W - 1));

  imgproc_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb0 (
    .clk(clk), .rst(rst), .push(push),
    .wr_data(push_data), .rd_data(lb0_out)
  );

  imgproc_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
    .clk(clk), .rst(rst), .push(push),
    .wr_data(lb0_out), .rd_data(lb1_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    cr_d    = cr_q;
    cc_d    = cc_q;
    if (push) begin
      if (pc_q == CW'(IMG_W - 1)) begin
        pc_d = '0;
        pr_d = pr_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
    if (emit) begin
      if (cc_q == CW'(IMG_W - 1)) begin
        cc_d = '0;
        cr_d = cr_q + 1'b1;
      end else begin
        cc_d = cc_q + 1'b1;
      end
    end
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_FILL;
        mode_d  = mode_e'(mode);
      end
      ST_FILL: if (emit) state_d = ST_RUN;
      ST_RUN:  if (accept && last_in) state_d = ST_FLUSH;
      ST_FLUSH: if (last_out) begin
        state_d = ST_IDLE;
        pr_d    = '0;
        pc_d    = '0;
        cr_d    = '0;
        cc_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stage 1: shift the window and capture the centre's border flags
  always_comb begin
    win_d     = win_q;
    s1_top_d  = s1_top_q;
    s1_bot_d  = s1_bot_q;
    s1_lft_d  = s1_lft_q;
    s1_rgt_d  = s1_rgt_q;
    s1_mode_d = s1_mode_q;
    if (push) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_out;
      win_d[1][2] = lb0_out;
      win_d[2][2] = push_data;
    end
    if (emit) begin
      s1_top_d  = (cr_q == '0);
      s1_bot_d  = (cr_q == RW'(IMG_H - 1));
      s1_lft_d  = (cc_q == '0);
      s1_rgt_d  = (cc_q == CW'(IMG_W - 1));
      s1_mode_d = mode_q;
    end
    vld_d  = {vld_q[LAT-2:0], emit};
    last_d = {last_q[LAT-2:0], emit && last_out};
  end

  // border taps: edge flags also hide wrapped columns and stale lines
  always_comb begin
    row_out = 1'b0;
    col_out = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        row_out = ((r == 0) && s1_top_q) || ((r == 2) && s1_bot_q);
        col_out = ((c == 0) && s1_lft_q) || ((c == 2) && s1_rgt_q);
`ifdef IMGPROC_BORDER_REPLICATE_EN
        tap_px[r][c] = win_q[row_out ? 1 : r][col_out ? 1 : c];
`else
        tap_px[r][c] = (row_out || col_out) ? '0 : win_q[r][c];
`endif
      end
    end
  end

  // stage 2: per-channel arithmetic
  always_comb begin
    res  = '0;
    px   = '0;
    ctr  = '0;
    gres = '0;
    lres = '0;
    gsum = '0;
    nsum = '0;
    lap  = '0;
    mag  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      gsum = '0;
      nsum = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          px   = tap_px[r][c][ch*DATA_W +: DATA_W];
          gsum = gsum + (ACC_W'(px) << gauss_sh(r, c));
          if (!((r == 1) && (c == 1))) nsum = nsum + NS_W'(px);
        end
      end
      ctr  = tap_px[1][1][ch*DATA_W +: DATA_W];
      gres = gsum[ACC_W-1:GAUSS_SHIFT];
      lap  = $signed({2'b00, ctr, 3'b000}) - $signed({2'b00, nsum});
      mag  = lap[LAP_W-1] ? -lap : lap;
      lres = (|mag[LAP_W-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
      unique case (s1_mode_q)
        MODE_GAUSS: res[ch*DATA_W +: DATA_W] = gres;
        MODE_LAPL:  res[ch*DATA_W +: DATA_W] = lres;
        default:    res[ch*DATA_W +: DATA_W] = ctr;
      endcase
    end
    out_data_d = vld_q[0] ? res : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_PASS;
      pr_q       <= '0;
      pc_q       <= '0;
      cr_q       <= '0;
      cc_q       <= '0;
      vld_q      <= '0;
      last_q     <= '0;
      s1_top_q   <= 1'b0;
      s1_bot_q   <= 1'b0;
      s1_lft_q   <= 1'b0;
      s1_rgt_q   <= 1'b0;
      s1_mode_q  <= MODE_PASS;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pr_q       <= pr_d;
      pc_q       <= pc_d;
      cr_q       <= cr_d;
      cc_q       <= cc_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      s1_top_q   <= s1_top_d;
      s1_bot_q   <= s1_bot_d;
      s1_lft_q   <= s1_lft_d;
      s1_rgt_q   <= s1_rgt_d;
      s1_mode_q  <= s1_mode_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign outputDataValid = vld_q[LAT-1];
  assign outputData      = out_data_q;
  assign frameDone       = last_q[LAT-1];

endmodule
